dual_frame_buffer: RTL

Parametrised double-buffered (ping-pong) frame store that sits between the game/sprite renderer (write side) and the VGA scan-out logic (read side).
- One buffer is "front" and is read for display; the other is "back" and takes renderer writes.
- Buffers swap only at the start of vertical blank, so the display never tears.
- Adds a hardware back-buffer clear engine and an auto-alternate mode for animated title screens (two-frame flicker) with a programmable period.

---
 rtl/dual_frame_buffer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/dual_frame_buffer.sv
// Ping-pong frame store: renderer writes the back buffer, scan-out reads the front,
// and the two swap only on a vertical-blank edge. Includes a back-buffer clear engine.
module dual_frame_buffer #(
   parameter int    PIXEL_W    = 5,
   parameter int    H_RES      = 640,
   parameter int    V_RES      = 480,
   parameter int    ADDR_W     = 19,
   parameter int    ALT_FRAMES = 64,
   parameter string INIT_FILE0 = "",
   parameter string INIT_FILE1 = ""
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               VS,
   input  logic [1:0]         mode,
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [PIXEL_W-1:0] rd_data,
   output logic               rd_valid,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [PIXEL_W-1:0] wr_data,
   input  logic               swap_req,
   input  logic               clear_req,
   input  logic [PIXEL_W-1:0] clear_color,
   output logic               busy,
   output logic               swap_pending,
   output logic               swap_done,
   output logic               front_sel,
   output logic [15:0]        frame_cnt
);

   localparam int DEPTH = H_RES * V_RES;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int ALT_W = (ALT_FRAMES > 1) ? $clog2(ALT_FRAMES) : 1;
   localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W + 1)'(DEPTH);
   localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);
   localparam logic [ALT_W-1:0] ALT_LAST = ALT_W'(ALT_FRAMES - 1);

   typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

   logic [PIXEL_W-1:0] mem0 [0:DEPTH-1];
   logic [PIXEL_W-1:0] mem1 [0:DEPTH-1];

   state_t             state_q, state_d;
   logic [AW-1:0]      ptr_q, ptr_d;
   logic [PIXEL_W-1:0] color_q, color_d;
   logic               vs_q;
   logic [1:0]         mode_q;
   logic               front_q, front_d;
   logic               pend_q, pend_d;
   logic               done_q, done_d;
   logic [ALT_W-1:0]   alt_q, alt_d;
   logic [15:0]        fcnt_q, fcnt_d;
   logic [PIXEL_W-1:0] rd_data_q;
   logic               rd_valid_q;

   logic               vs_fall_s;
   logic               busy_s;
   logic               mem_we_s;
   logic [AW-1:0]      mem_waddr_s;
   logic [PIXEL_W-1:0] mem_wdata_s;

   assign vs_fall_s = vs_q & ~VS;
   assign busy_s    = (state_q == S_CLEAR);

   // Clear engine next-state: one pixel per cycle from 0 to DEPTH-1
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      color_d = color_q;
      case (state_q)
         S_IDLE: begin
            if (clear_req) begin
               state_d = S_CLEAR;
               ptr_d   = '0;
               color_d = clear_color;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
            if (ptr_q == LAST_PTR) begin
               state_d = S_IDLE;
            end else begin
               ptr_d = ptr_q + AW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Single back-buffer write port; front_sel is frozen while clearing, so !front is the fixed target
   always_comb begin
      mem_we_s    = 1'b0;
      mem_waddr_s = '0;
      mem_wdata_s = '0;
      if (state_q == S_CLEAR) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = ptr_q;
         mem_wdata_s = color_q;
      end else if (wr_en && ({1'b0, wr_addr} < DEPTH_A)) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = wr_addr[AW-1:0];
         mem_wdata_s = wr_data;
      end else begin
         mem_we_s    = 1'b0;
      end
   end

   // Swap / alternate / hold control, evaluated on vblank start
   always_comb begin
      front_d = front_q;
      pend_d  = pend_q;
      done_d  = 1'b0;
      alt_d   = alt_q;
      fcnt_d  = fcnt_q + {15'd0, vs_fall_s};
      case (mode)
         2'b01: begin
            pend_d = 1'b0;
            if (vs_fall_s) begin
               if (alt_q == ALT_LAST) begin
                  if (!busy_s) begin
                     front_d = ~front_q;
                     alt_d   = '0;
                     done_d  = 1'b1;
                  end else begin
                     alt_d = alt_q;
                  end
               end else begin
                  alt_d = alt_q + ALT_W'(1);
               end
            end else begin
               alt_d = alt_q;
            end
         end
         2'b10: begin
            pend_d = pend_q | swap_req;
            if (vs_fall_s && !busy_s && front_q) begin
               front_d = 1'b0;
               done_d  = 1'b1;
            end else begin
               front_d = front_q;
            end
         end
         default: begin
            pend_d = pend_q | swap_req;
            if (vs_fall_s && pend_d && !busy_s) begin
               front_d = ~front_q;
               pend_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               front_d = front_q;
            end
         end
      endcase
      if (mode != mode_q) begin
         alt_d = '0;
      end else begin
         alt_d = alt_d;
      end
   end

   // Control and status registers
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         color_q <= '0;
         vs_q    <= 1'b1;
         mode_q  <= 2'b00;
         front_q <= 1'b0;
         pend_q  <= 1'b0;
         done_q  <= 1'b0;
         alt_q   <= '0;
         fcnt_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         color_q <= color_d;
         vs_q    <= VS;
         mode_q  <= mode;
         front_q <= front_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
         alt_q   <= alt_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // Front-buffer read, one cycle latency; uses front_sel before any same-cycle swap
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) begin
            if ({1'b0, rd_addr} < DEPTH_A) begin
               rd_data_q <= front_q ? mem1[rd_addr[AW-1:0]] : mem0[rd_addr[AW-1:0]];
            end else begin
               rd_data_q <= '0;
            end
         end
      end
   end

   // Buffer RAM writes; contents survive reset
   always_ff @(posedge Clk) begin
      if (mem_we_s && front_q) begin
         mem0[mem_waddr_s] <= mem_wdata_s;
      end
      if (mem_we_s && !front_q) begin
         mem1[mem_waddr_s] <= mem_wdata_s;
      end
   end

   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign busy         = busy_s;
   assign swap_pending = pend_q;
   assign swap_done    = done_q;
   assign front_sel    = front_q;
   assign frame_cnt    = fcnt_q;

endmodule
